// File: rtl/game_phase_ctrl.sv
// rtl/game_phase_ctrl.sv - Bricks game phase sequencer with shared phase timer
//
// Purpose:
//   Owns the game phase state machine (IDLE, READY, PLAY, LIFE_LOST,
//   GAME_OVER, WIN and, optionally, PAUSED). A single down-counter times
//   every timed phase. Drives the phase code, play enable, ball re-spawn
//   pulse and remaining lives to the drawing and physics logic.
//
// Optional feature macro:
//   GAME_PAUSE_EN - when defined, a start edge in PLAY enters PAUSED and the
//                   next start edge returns to PLAY. When undefined, PAUSED
//                   is not built and code 6 is never produced.
//
// Ports:
//   clk            in   1  system clock
//   resetN         in   1  asynchronous active-low reset
//   start          in   1  start key level, already synchronized to clk
//   ball_lost      in   1  pulse: ball left the bottom edge
//   bricks_cleared in   1  pulse: last brick destroyed
//   bgState        out  3  phase code (0 IDLE .. 6 PAUSED)
//   play_en        out  1  high only in PLAY
//   ball_reset     out  1  pulse on the first cycle of READY
//   lives          out  3  remaining lives

module game_phase_ctrl #(
  parameter int                 CNT_W      = 26,
  parameter logic [CNT_W-1:0]   READY_TIME = 26'd20_000_000,
  parameter logic [CNT_W-1:0]   PAUSE_TIME = 26'd10_000_000,
  parameter logic [CNT_W-1:0]   END_TIME   = 26'd50_000_000,
  parameter logic [2:0]         LIVES      = 3'd3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic [2:0] bgState,
  output logic       play_en,
  output logic       ball_reset,
  output logic [2:0] lives
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_PLAY      = 3'd2,
    S_LIFE_LOST = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5
`ifdef GAME_PAUSE_EN
    ,
    S_PAUSED    = 3'd6
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_lives;
  logic             r_start_q;
  logic             r_play_en;
  logic             r_ball_reset;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_lives_nxt;
  logic             w_ball_reset_nxt;
  logic             w_start_rise;
  logic             w_cnt_zero;

  // r_start_q resets high so a key held through reset release is not an edge.
  assign w_start_rise = start & ~r_start_q;
  assign w_cnt_zero   = (r_cnt == CNT_ZERO);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_cnt        <= CNT_ZERO;
      r_lives      <= 3'd0;
      r_start_q    <= 1'b1;
      r_play_en    <= 1'b0;
      r_ball_reset <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lives      <= w_lives_nxt;
      r_start_q    <= start;
      r_play_en    <= (w_state_nxt == S_PLAY);
      r_ball_reset <= w_ball_reset_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    // Free-running decrement that saturates at zero; phase entries override it.
    w_cnt_nxt        = w_cnt_zero ? CNT_ZERO : (r_cnt - CNT_ONE);
    w_lives_nxt      = r_lives;
    w_ball_reset_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt      = S_READY;
          w_cnt_nxt        = READY_TIME;
          w_lives_nxt      = LIVES;
          w_ball_reset_nxt = 1'b1;
        end
      end

      S_READY: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_PLAY;
        end
      end

      S_PLAY: begin
        // Clearing the last brick wins over a ball lost in the same cycle.
        if (bricks_cleared) begin
          w_state_nxt = S_WIN;
          w_cnt_nxt   = END_TIME;
        end else if (ball_lost) begin
          if (r_lives > 3'd1) begin
            w_lives_nxt = r_lives - 3'd1;
            w_state_nxt = S_LIFE_LOST;
            w_cnt_nxt   = PAUSE_TIME;
          end else begin
            w_lives_nxt = 3'd0;
            w_state_nxt = S_GAME_OVER;
            w_cnt_nxt   = END_TIME;
          end
        end
`ifdef GAME_PAUSE_EN
        else if (w_start_rise) begin
          w_state_nxt = S_PAUSED;
          w_cnt_nxt   = r_cnt;
        end
`endif
      end

      S_LIFE_LOST: begin
        if (w_cnt_zero) begin
          w_state_nxt      = S_READY;
          w_cnt_nxt        = READY_TIME;
          w_ball_reset_nxt = 1'b1;
        end
      end

      S_GAME_OVER, S_WIN: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
        end
      end

`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        // Timer and lives are frozen; collision pulses are ignored here.
        w_cnt_nxt = r_cnt;
        if (w_start_rise) begin
          w_state_nxt = S_PLAY;
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign bgState    = r_state;
  assign play_en    = r_play_en;
  assign ball_reset = r_ball_reset;
  assign lives      = r_lives;

endmodule
